// File: rtl/matrix_alu_pkg.sv
// Shared encodings and index helpers for the sequential matrix ALU.
// Matrices are packed row-major with element 0 at the LSB.
package matrix_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MUL  = 2'b10,
        OP_KRON = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        MAC_ADD = 2'b00,
        MAC_SUB = 2'b01,
        MAC_MUL = 2'b10,
        MAC_MAC = 2'b11
    } mac_mode_e;

    // Row-major flat element index of (row, col) in a matrix with ncols columns.
    function automatic logic [31:0] elem_idx(input logic [31:0] row, input logic [31:0] col,
                                             input logic [31:0] ncols);
        return row * ncols + col;
    endfunction

endpackage

// File: rtl/matrix_alu_mac.sv
// Shared element datapath: add, subtract, multiply or multiply-accumulate.
// The result is combinational; the accumulator register takes it (or zero on clr) when en.
module matrix_alu_mac
    import matrix_alu_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 clr,
    input  mac_mode_e            mode,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    output logic [WORD_SIZE-1:0] res
);

    logic [WORD_SIZE-1:0] acc_q;
    logic [WORD_SIZE-1:0] acc_d;

    always_comb begin
        res = '0;
        case (mode)
            MAC_ADD: res = a + b;
            MAC_SUB: res = a - b;
            MAC_MUL: res = a * b;
            MAC_MAC: res = acc_q + a * b;
        endcase
        acc_d = acc_q;
        if (en) begin
            acc_d = clr ? '0 : res;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/matrix_alu_seq.sv
// Sequential matrix ALU: one shared MAC walks the result elements with nested counters
// (i outermost, l innermost); valid/ready on both sides plus a dimension-error flag.
module matrix_alu_seq
    import matrix_alu_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int A_ROWS    = 2,
    parameter int A_COLS    = 2,
    parameter int B_ROWS    = 2,
    parameter int B_COLS    = 2
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              in_valid,
    output logic                                              in_ready,
    input  logic [A_ROWS*A_COLS*WORD_SIZE-1:0]                A,
    input  logic [B_ROWS*B_COLS*WORD_SIZE-1:0]                B,
    input  logic [1:0]                                        op,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic [A_ROWS*A_COLS*B_ROWS*B_COLS*WORD_SIZE-1:0]  C,
    output logic                                              err,
    output logic [1:0]                                        dbg_state
);

    localparam int NA = A_ROWS * A_COLS;
    localparam int NB = B_ROWS * B_COLS;
    localparam int NC = NA * NB;
    localparam bit ADDSUB_OK = (A_ROWS == B_ROWS) && (A_COLS == B_COLS);
    localparam bit MUL_OK    = (A_COLS == B_ROWS);

    // Handshake: an input is taken on a rising edge with in_valid && in_ready; a result
    // is retired on a rising edge with out_valid && out_ready. C/err hold while out_valid.
    state_e                   state_q, state_d;
    op_e                      op_q, op_d;
    logic [NA*WORD_SIZE-1:0]  a_q, a_d;
    logic [NB*WORD_SIZE-1:0]  b_q, b_d;
    logic [NC*WORD_SIZE-1:0]  res_q, res_d;
    logic                     err_q, err_d;
    logic [31:0]              i_q, i_d, j_q, j_d, k_q, k_d, l_q, l_d;

    logic [31:0]              last_i, last_j, last_k, last_l;
    logic [31:0]              a_idx, b_idx, c_idx;
    logic [WORD_SIZE-1:0]     a_el, b_el, mac_res;
    mac_mode_e                mac_mode;
    logic                     mac_en, mac_clr, op_ok;
    logic                     wrap_l, wrap_k, wrap_j, last_step, wr_elem;

    assign op_ok = (op == OP_ADD || op == OP_SUB) ? ADDSUB_OK :
                   (op == OP_MUL) ? MUL_OK : 1'b1;

    // Per-op loop bounds and operand/result element indices.
    always_comb begin
        last_i   = A_ROWS - 1;
        last_j   = '0;
        last_k   = '0;
        last_l   = '0;
        a_idx    = elem_idx(i_q, j_q, A_COLS);
        b_idx    = elem_idx(i_q, j_q, B_COLS);
        c_idx    = elem_idx(i_q, j_q, A_COLS);
        mac_mode = MAC_ADD;
        case (op_q)
            OP_ADD, OP_SUB: begin
                last_j   = A_COLS - 1;
                mac_mode = (op_q == OP_SUB) ? MAC_SUB : MAC_ADD;
            end
            OP_MUL: begin
                last_j   = B_COLS - 1;
                last_k   = A_COLS - 1;
                a_idx    = elem_idx(i_q, k_q, A_COLS);
                b_idx    = elem_idx(k_q, j_q, B_COLS);
                c_idx    = elem_idx(i_q, j_q, B_COLS);
                mac_mode = MAC_MAC;
            end
            OP_KRON: begin
                last_j   = A_COLS - 1;
                last_k   = B_ROWS - 1;
                last_l   = B_COLS - 1;
                b_idx    = elem_idx(k_q, l_q, B_COLS);
                c_idx    = elem_idx(elem_idx(i_q, k_q, B_ROWS), elem_idx(j_q, l_q, B_COLS),
                                    A_COLS * B_COLS);
                mac_mode = MAC_MUL;
            end
        endcase
    end

    always_comb begin
        a_el = '0;
        for (int n = 0; n < NA; n++) begin
            if (a_idx == n) a_el = a_q[n*WORD_SIZE +: WORD_SIZE];
        end
        b_el = '0;
        for (int n = 0; n < NB; n++) begin
            if (b_idx == n) b_el = b_q[n*WORD_SIZE +: WORD_SIZE];
        end
    end

    assign wrap_l    = (l_q == last_l);
    assign wrap_k    = wrap_l && (k_q == last_k);
    assign wrap_j    = wrap_k && (j_q == last_j);
    assign last_step = wrap_j && (i_q == last_i);
    // Only a multiply spends several steps per element; its accumulator clears on write.
    assign wr_elem   = (op_q != OP_MUL) || (k_q == last_k);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        err_d   = err_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        l_d     = l_q;
        mac_en  = 1'b0;
        mac_clr = 1'b1;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = op_e'(op);
                    res_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    l_d     = '0;
                    mac_en  = 1'b1;
                    err_d   = !op_ok;
                    state_d = op_ok ? CALC : DONE;
                end
            end
            CALC: begin
                mac_en  = 1'b1;
                mac_clr = wr_elem;
                if (wr_elem) begin
                    for (int n = 0; n < NC; n++) begin
                        if (c_idx == n) res_d[n*WORD_SIZE +: WORD_SIZE] = mac_res;
                    end
                end
                l_d = wrap_l ? '0 : l_q + 32'd1;
                k_d = wrap_k ? '0 : (wrap_l ? k_q + 32'd1 : k_q);
                j_d = wrap_j ? '0 : (wrap_k ? j_q + 32'd1 : j_q);
                i_d = last_step ? '0 : (wrap_j ? i_q + 32'd1 : i_q);
                if (last_step) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            l_q     <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            l_q     <= l_d;
        end
    end

    matrix_alu_mac #(.WORD_SIZE(WORD_SIZE)) u_mac (
        .clk   (clk),
        .reset (reset),
        .en    (mac_en),
        .clr   (mac_clr),
        .mode  (mac_mode),
        .a     (a_el),
        .b     (b_el),
        .res   (mac_res)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign C         = res_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_matrix_alu_seq.sv
// Directed bench for matrix_alu_seq: a default 2x2 instance and a 2x3/2x3 instance
// for the dimension-error path.
module tb_matrix_alu_seq;

    localparam int W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid, in_ready, out_valid, out_ready, err;
    logic [4*W-1:0]   a_in, b_in;
    logic [1:0]       op_in, dbg_state;
    logic [16*W-1:0]  c_out;

    logic             r_in_valid, r_in_ready, r_out_valid, r_out_ready, r_err;
    logic [6*W-1:0]   r_a, r_b;
    logic [1:0]       r_op, r_dbg;
    logic [36*W-1:0]  r_c;

    int errors = 0;
    int checks = 0;

    matrix_alu_seq #(.WORD_SIZE(W), .A_ROWS(2), .A_COLS(2), .B_ROWS(2), .B_COLS(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(a_in), .B(b_in), .op(op_in), .out_valid(out_valid), .out_ready(out_ready),
        .C(c_out), .err(err), .dbg_state(dbg_state)
    );

    matrix_alu_seq #(.WORD_SIZE(W), .A_ROWS(2), .A_COLS(3), .B_ROWS(2), .B_COLS(3)) dut_r (
        .clk(clk), .reset(reset), .in_valid(r_in_valid), .in_ready(r_in_ready),
        .A(r_a), .B(r_b), .op(r_op), .out_valid(r_out_valid), .out_ready(r_out_ready),
        .C(r_c), .err(r_err), .dbg_state(r_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] el(input logic [16*W-1:0] v, input int i);
        return W'(v >> (i * W));
    endfunction

    function automatic logic [W-1:0] el_r(input logic [36*W-1:0] v, input int i);
        return W'(v >> (i * W));
    endfunction

    // Called at a negedge; holds in_valid until an edge with in_ready high takes it.
    task automatic apply_op(input logic [1:0] o, output int waited);
        logic rdy;
        op_in = o;
        in_valid = 1'b1;
        waited = 0;
        while (waited < 50) begin
            rdy = in_ready;
            @(posedge clk);
            if (rdy) break;
            waited++;
            @(negedge clk);
        end
    endtask

    // Called right after the accept edge; returns at the negedge where out_valid is seen.
    task automatic wait_result(output int edges, output int busy_bad);
        edges = 0;
        busy_bad = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && edges < 100) begin
            if (in_ready) busy_bad++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (c_out !== '0) begin errors++; $display("FAIL reset_c: got %h expected 0", c_out); end
        checks++; if (dbg_state !== 2'b00) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        checks++; if (r_in_ready !== 1'b1) begin errors++; $display("FAIL reset_r_in_ready: got %b expected 1", r_in_ready); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_add();
        int waited, edges, busy_bad;
        logic [W-1:0] exp_c [4];
        exp_c = '{32'd6, 32'd8, 32'd10, 32'd8};
        @(negedge clk);
        apply_op(2'b00, waited);
        wait_result(edges, busy_bad);
        checks++; if (waited != 0) begin errors++; $display("FAIL add_accept: waited %0d expected 0", waited); end
        checks++; if (edges != 4) begin errors++; $display("FAIL add_latency: got %0d expected 4", edges); end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL add_busy_ready: in_ready high %0d cycles expected 0", busy_bad); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL add_err: got %b expected 0", err); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (el(c_out, i) !== exp_c[i]) begin errors++; $display("FAIL add_c%0d: got %0d expected %0d", i, el(c_out, i), exp_c[i]); end
        end
        checks++; if ((c_out >> (4 * W)) !== '0) begin errors++; $display("FAIL add_upper: got %h expected 0", c_out >> (4 * W)); end
    endtask

    task automatic test_sub();
        int waited, edges, busy_bad;
        logic [W-1:0] exp_c [4];
        exp_c = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFF8};
        @(negedge clk);
        apply_op(2'b01, waited);
        // Inputs changing mid-operation must not disturb the captured operands.
        #1;
        a_in = {4{32'hDEAD_BEEF}};
        b_in = {4{32'h1234_5678}};
        op_in = 2'b11;
        wait_result(edges, busy_bad);
        checks++; if (edges != 4) begin errors++; $display("FAIL sub_latency: got %0d expected 4", edges); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL sub_err: got %b expected 0", err); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (el(c_out, i) !== exp_c[i]) begin errors++; $display("FAIL sub_c%0d: got %h expected %h", i, el(c_out, i), exp_c[i]); end
        end
        a_in = {32'd0, 32'd3, 32'd2, 32'd1};
        b_in = {32'd8, 32'd7, 32'd6, 32'd5};
    endtask

    task automatic test_back_to_back();
        int waited, edges, busy_bad;
        logic [W-1:0] exp_m [4];
        logic [W-1:0] exp_k [16];
        exp_m = '{32'd19, 32'd22, 32'd15, 32'd18};
        exp_k = '{32'd5, 32'd6, 32'd10, 32'd12, 32'd7, 32'd8, 32'd14, 32'd16,
                  32'd15, 32'd18, 32'd0, 32'd0, 32'd21, 32'd24, 32'd0, 32'd0};
        @(negedge clk);
        apply_op(2'b10, waited);
        wait_result(edges, busy_bad);
        checks++; if (edges != 8) begin errors++; $display("FAIL mul_latency: got %0d expected 8", edges); end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL mul_busy_ready: in_ready high %0d cycles expected 0", busy_bad); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (el(c_out, i) !== exp_m[i]) begin errors++; $display("FAIL mul_c%0d: got %0d expected %0d", i, el(c_out, i), exp_m[i]); end
        end
        apply_op(2'b11, waited);
        checks++; if (waited != 1) begin errors++; $display("FAIL b2b_accept: waited %0d expected 1", waited); end
        wait_result(edges, busy_bad);
        checks++; if (edges != 16) begin errors++; $display("FAIL kron_latency: got %0d expected 16", edges); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL kron_err: got %b expected 0", err); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (el(c_out, i) !== exp_k[i]) begin errors++; $display("FAIL kron_c%0d: got %0d expected %0d", i, el(c_out, i), exp_k[i]); end
        end
    endtask

    task automatic test_backpressure();
        int waited, edges, busy_bad;
        logic [W-1:0] exp_m [4];
        exp_m = '{32'd19, 32'd22, 32'd15, 32'd18};
        @(negedge clk);
        out_ready = 1'b0;
        apply_op(2'b10, waited);
        wait_result(edges, busy_bad);
        checks++; if (edges != 8) begin errors++; $display("FAIL bp_latency: got %0d expected 8", edges); end
        for (int cyc = 0; cyc < 5; cyc++) begin
            in_valid = 1'b1;
            op_in = 2'b00;
            a_in = {4{32'h0000_0100}};
            @(posedge clk);
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: cycle %0d got %b expected 1", cyc, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready: cycle %0d got %b expected 0", cyc, in_ready); end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (el(c_out, i) !== exp_m[i]) begin errors++; $display("FAIL bp_hold_c%0d: cycle %0d got %0d expected %0d", i, cyc, el(c_out, i), exp_m[i]); end
            end
        end
        in_valid = 1'b0;
        a_in = {32'd0, 32'd3, 32'd2, 32'd1};
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_reset_mid_op();
        int waited, edges, busy_bad;
        logic [W-1:0] exp_a [4];
        logic [W-1:0] exp_m [4];
        exp_a = '{32'd6, 32'd8, 32'd10, 32'd8};
        exp_m = '{32'd19, 32'd22, 32'd15, 32'd18};
        @(negedge clk);
        apply_op(2'b10, waited);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (c_out !== '0) begin errors++; $display("FAIL rst_mid_c: got %h expected 0", c_out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        reset = 1'b0;
        apply_op(2'b00, waited);
        wait_result(edges, busy_bad);
        checks++; if (edges != 4) begin errors++; $display("FAIL rst_add_latency: got %0d expected 4", edges); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (el(c_out, i) !== exp_a[i]) begin errors++; $display("FAIL rst_add_c%0d: got %0d expected %0d", i, el(c_out, i), exp_a[i]); end
        end
        @(negedge clk);
        apply_op(2'b10, waited);
        wait_result(edges, busy_bad);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (el(c_out, i) !== exp_m[i]) begin errors++; $display("FAIL rst_mul_c%0d: got %0d expected %0d", i, el(c_out, i), exp_m[i]); end
        end
    endtask

    task automatic test_illegal_dims();
        int edges;
        @(negedge clk);
        checks++; if (r_in_ready !== 1'b1) begin errors++; $display("FAIL ill_idle_ready: got %b expected 1", r_in_ready); end
        r_op = 2'b10;
        r_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r_in_valid = 1'b0;
        checks++; if (r_out_valid !== 1'b1) begin errors++; $display("FAIL ill_valid: got %b expected 1", r_out_valid); end
        checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL ill_err: got %b expected 1", r_err); end
        checks++; if (r_c !== '0) begin errors++; $display("FAIL ill_c: got %h expected 0", r_c); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (r_out_valid !== 1'b0) begin errors++; $display("FAIL ill_release: got %b expected 0", r_out_valid); end
        r_op = 2'b00;
        r_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r_in_valid = 1'b0;
        edges = 0;
        while (!r_out_valid && edges < 50) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        checks++; if (edges != 6) begin errors++; $display("FAIL r_add_latency: got %0d expected 6", edges); end
        checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL r_add_err: got %b expected 0", r_err); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (el_r(r_c, i) !== W'((i + 1) * 11)) begin errors++; $display("FAIL r_add_c%0d: got %0d expected %0d", i, el_r(r_c, i), (i + 1) * 11); end
        end
        checks++; if ((r_c >> (6 * W)) !== '0) begin errors++; $display("FAIL r_add_upper: got %h expected 0", r_c >> (6 * W)); end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op_in = 2'b00;
        a_in = {32'd0, 32'd3, 32'd2, 32'd1};
        b_in = {32'd8, 32'd7, 32'd6, 32'd5};
        r_in_valid = 1'b0;
        r_out_ready = 1'b1;
        r_op = 2'b00;
        r_a = {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
        r_b = {32'd60, 32'd50, 32'd40, 32'd30, 32'd20, 32'd10};
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_op();
        test_illegal_dims();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matrix_alu_seq.md
Name: matrix_alu_seq

Overview:
- Parametrised, sequential successor to the combinational matrix ALU: add, subtract, matrix multiply and Kronecker product on arbitrary-size integer matrices.
- Uses one shared multiply/add datapath that iterates over result elements, so area stays flat as dimensions grow.
- Valid/ready handshakes on input and output, plus a dimension-error flag.
- Sits between the matrix operand registers and the result consumer.

Parameters:
- WORD_SIZE, 32, element width in bits
- A_ROWS, 2, rows of A
- A_COLS, 2, columns of A
- B_ROWS, 2, rows of B
- B_COLS, 2, columns of B

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operands and op valid
- in_ready  out  1  block idle, can accept
- A  in  A_ROWS*A_COLS*WORD_SIZE  matrix A, row-major, element (r,c) at [(r*A_COLS+c)*WORD_SIZE +: WORD_SIZE]
- B  in  B_ROWS*B_COLS*WORD_SIZE  matrix B, same packing with B_COLS
- op  in  2  00 add, 01 sub (A-B), 10 multiply (A*B), 11 Kronecker (A⊗B)
- out_valid  out  1  result C/err valid
- out_ready  in  1  consumer takes result
- C  out  A_ROWS*A_COLS*B_ROWS*B_COLS*WORD_SIZE  result, row-major, element 0 at LSB, unused upper elements zero
- err  out  1  op illegal for configured dimensions

Behaviour:
- Reset (asynchronous, active-high, any state including mid-operation):
  - state IDLE, counters 0, operand regs 0.
  - C=0, err=0, out_valid=0, in_ready=1.
  - Any partial result is discarded.
- States and transitions:
  - IDLE: in_ready=1. in_valid is sampled on the rising edge (accept edge); A, B and op are registered, the C register is cleared, and the ALU moves to CALC, or to DONE with err=1 if the op is illegal.
  - CALC: in_ready=0. Performs one datapath step per clock and moves to DONE on the edge that writes the last element.
  - DONE: out_valid=1; C and err are held stable. The ALU returns to IDLE on the edge where out_ready=1. With out_ready low, it stays in DONE indefinitely.
  - Input is never accepted in DONE, so operations do not overlap. After the DONE→IDLE edge, the next accept can occur on the following edge.
- Illegal ops:
  - add/sub when A_ROWS!=B_ROWS or A_COLS!=B_COLS.
  - multiply when A_COLS!=B_ROWS.
  - Response: C=0, err=1, out_valid 1 edge after the accept edge.
- Step counts (L = edges from accept to out_valid high):
  - add/sub: L=A_ROWS*A_COLS. C(r,c)=A(r,c)±B(r,c) at index r*A_COLS+c.
  - multiply: L=A_ROWS*B_COLS*A_COLS. Inner counter k accumulates acc+=A(r,k)*B(k,c); acc is written on k=A_COLS-1 and cleared for the next element. C(r,c) is at index r*B_COLS+c.
  - Kronecker: L=A_ROWS*A_COLS*B_ROWS*B_COLS. C(ia*B_ROWS+ib, ja*B_COLS+jb)=A(ia,ja)*B(ib,jb). The result row length is A_COLS*B_COLS.
- Arithmetic: unsigned, modulo 2^WORD_SIZE. Products and sums are truncated to WORD_SIZE every step; no overflow flag. Sub wraps two's-complement.
- Counters: r, c, k, plus the Kronecker indices, are nested and wrap to 0 at their bound. The outer counter is incremented only on inner wrap.
- op and operands are captured at accept; later changes to the A, B and op inputs have no effect until the next accept.

Decomposition:
- matrix_alu_pkg holds:
  - op encodings OP_ADD/OP_SUB/OP_MUL/OP_KRON
  - state enum IDLE/CALC/DONE
  - element-index helper functions (row-major offset)
- Sub-module matrix_alu_mac:
  - registered WORD_SIZE multiply-accumulate with mode select (add, sub, mul, mac) and accumulator clear.
  - one instance, driven by the controller FSM in matrix_alu_seq.

Test Plan (defaults 2x2, WORD_SIZE=32; A(0,0..1)=1,2 A(1,0..1)=3,0; B(0,0..1)=5,6 B(1,0..1)=7,8; out_ready=1 unless noted):
- op=00 → after 4 edges out_valid=1, C elements 0..3 = 6,8,10,8, upper 12 elements 0, err=0; in_ready=0 while busy.
- op=01 → after 4 edges C elements 0..3 = 0xFFFFFFFC,0xFFFFFFFC,0xFFFFFFFC,0xFFFFFFF8.
- op=10 → after 8 edges C elements 0..3 = 19,22,15,18; back-to-back: op=11 accepted the edge after the DONE→IDLE edge → after 16 edges C row0 = 5,6,10,12, row3 = 21,24,0,0.
- Rebuild A_ROWS=2,A_COLS=3,B_ROWS=2,B_COLS=3, op=10 → out_valid after 1 edge, err=1, C=0; then op=00 → err=0, correct sums.
- op=10, hold out_ready=0 for 5 cycles after out_valid → C stable at 19,22,15,18, out_valid held, in_ready=0, in_valid pulses ignored; out_ready=1 → IDLE next edge.
- Assert reset at step 3 of a multiply → immediately C=0, out_valid=0, in_ready=1; a new op=00 after reset deasserts yields 6,8,10,8 with no residue.
